// File: rtl/apb_pkg.sv
// Shared state type and default bus widths for the APB rev B master.
package apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_master_state_e;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase watchdog: counts stalled ACCESS cycles and flags the cycle whose
// increment would reach TIMEOUT_CYCLES. Only built with APB_MASTER_TIMEOUT_EN.
module apb_timeout_ctr
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic cnt_en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (cnt_en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expiry is flagged combinationally so the abort lands on the same edge as the last count.
    assign expired_o = cnt_en_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_rev_b_master.sv
// APB rev B master: turns a valid/ready command into one APB transfer and returns a response.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES.
module apb_rev_b_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH     = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    apb_master_state_e     state_q;
    logic                  cmd_ready_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_slverr_q;
    logic                  timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (pclk),
        .rst_ni   (presetn),
        .clear_i  (state_q == SETUP),
        .cnt_en_i ((state_q == ACCESS) && !pready),
        .expired_o(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        paddr_q     <= cmd_addr;
                        pwrite_q    <= cmd_write;
                        pwdata_q    <= cmd_wdata;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // pready is checked first so a completion on the expiry cycle still succeeds.
                    if (pready) begin
                        rsp_rdata_q  <= pwrite_q ? '0 : prdata;
                        rsp_slverr_q <= pslverr;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end else if (timeout) begin
                        rsp_rdata_q  <= '0;
                        rsp_slverr_q <= 1'b1;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign pselx      = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;

endmodule
